// File: rtl/dcache_wt.sv
// dcache_wt: direct-mapped, write-through, no-write-allocate data cache with
// one-word lines, placed between a single-issue core and a fixed-latency
// 4-byte-lane data memory.
//
// Optional feature macro: DCACHE_STATS_EN
//   Defined   -> adds hit_count / miss_count outputs (wrapping, cleared by reset).
//   Undefined -> no counters and no counter ports.
//
// Core handshake: the core raises core_req with core_we/core_addr/core_wdata
// and must keep them stable for as long as core_stall is high. A request is
// retired in the first cycle in which core_req=1 and core_stall=0: either an
// IDLE read hit (data presented combinationally) or the RESP cycle that ends a
// miss or a write. In RESP the request is dropped by the cache whatever
// core_req shows; a new request is only looked at in IDLE the cycle after.
//
// Memory side: mem_addr and mem_data_in come straight from the request
// registers. mem_write_en is high for exactly MEM_LAT cycles per store.
// A read miss holds mem_addr for MEM_LAT cycles and samples mem_data_out in
// the last of them.
module dcache_wt #(
  parameter int  ADDR_W  = 32,
  parameter int  INDEX_W = 4,
  parameter int  MEM_LAT = 4,
  localparam int TAG_W   = ADDR_W - INDEX_W - 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic [31:0]       core_rdata,
  output logic              core_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out,
  output logic              mem_write_en,
`ifdef DCACHE_STATS_EN
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
`endif
  output logic [1:0]        dbg_state_o
);

  localparam int LINES = 1 << INDEX_W;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int WA_W  = ADDR_W - 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RMISS = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WA_W-1:0]   waddr_q, waddr_d;   // word address of the pending request
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;   // response / hold register for core_rdata

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [31:0]       data_q [LINES];

  // Request decode (live core address) and pending-request decode (registers)
  logic [INDEX_W-1:0] req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic               req_hit;
  logic [INDEX_W-1:0] reg_idx;
  logic [TAG_W-1:0]   reg_tag;
  logic               reg_hit;
  logic               last_cycle;

  // Control strobes from the FSM
  logic               hit_rd;      // IDLE read hit this cycle
  logic               miss_start;  // IDLE read miss this cycle
  logic               fill_en;     // last RMISS cycle: install memory data
  logic               wr_upd_en;   // last WRITE cycle on a resident line

  // Byte-offset bits never select anything in a word-wide cache.
  logic               unused_addr_bits;
  assign unused_addr_bits = ^core_addr[1:0];

  assign req_idx    = core_addr[INDEX_W+1:2];
  assign req_tag    = core_addr[ADDR_W-1:INDEX_W+2];
  assign req_hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign reg_idx    = waddr_q[INDEX_W-1:0];
  assign reg_tag    = waddr_q[WA_W-1:INDEX_W];
  assign reg_hit    = valid_q[reg_idx] && (tag_q[reg_idx] == reg_tag);
  assign last_cycle = (cnt_q == CNT_W'(MEM_LAT - 1));

  assign mem_addr    = {waddr_q, 2'b00};
  assign mem_data_in = wdata_q;
  assign dbg_state_o = state_q;

  // Read hits bypass the hold register so the data is visible in the same cycle
  assign core_rdata = hit_rd ? data_q[req_idx] : rdata_q;

  // Next-state and output decode for the request FSM
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    core_stall   = 1'b0;
    mem_write_en = 1'b0;
    hit_rd       = 1'b0;
    miss_start   = 1'b0;
    fill_en      = 1'b0;
    wr_upd_en    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (core_req) begin
          if (core_we) begin
            core_stall = 1'b1;
            waddr_d    = core_addr[ADDR_W-1:2];
            wdata_d    = core_wdata;
            cnt_d      = '0;
            state_d    = S_WRITE;
          end else if (req_hit) begin
            hit_rd = 1'b1;
          end else begin
            core_stall = 1'b1;
            miss_start = 1'b1;
            waddr_d    = core_addr[ADDR_W-1:2];
            cnt_d      = '0;
            state_d    = S_RMISS;
          end
        end
      end
      S_RMISS: begin
        core_stall = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        if (last_cycle) begin
          fill_en = 1'b1;
          cnt_d   = '0;
          state_d = S_RESP;
        end
      end
      S_WRITE: begin
        core_stall   = 1'b1;
        mem_write_en = 1'b1;
        cnt_d        = cnt_q + CNT_W'(1);
        if (last_cycle) begin
          // No allocate: only a line already holding this address is refreshed
          wr_upd_en = reg_hit;
          cnt_d     = '0;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Response/hold register: follows the most recent load data shown to the core
  always_comb begin
    rdata_d = rdata_q;
    if (hit_rd) begin
      rdata_d = data_q[req_idx];
    end else if (fill_en) begin
      rdata_d = mem_data_out;
    end
  end

  // FSM state, beat counter and request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Valid bits: cleared by reset, set when a miss fills its line
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[reg_idx] <= 1'b1;
    end
  end

  // Tag/data arrays; contents are don't-care while the valid bit is low
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[reg_idx]  <= reg_tag;
      data_q[reg_idx] <= mem_data_out;
    end else if (wr_upd_en) begin
      data_q[reg_idx] <= wdata_q;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Hit/miss statistics for loads; stores are not counted
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_rd)     hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
